// File: rtl/usb_ctrl_pkg.sv
// Shared USB controller types: packet kinds, scheduler result codes and FSM states.
package usb_ctrl_pkg;

  typedef enum logic [1:0] {
    PKT_ACK   = 2'd0,
    PKT_NAK   = 2'd1,
    PKT_DATA  = 2'd2,
    PKT_STALL = 2'd3
  } tx_packet_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_EMPTY   = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_TXERR   = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_START,
    S_ACTIVE,
    S_FLUSH,
    S_DONE,
    S_ERR
  } sched_state_t;

endpackage

// File: rtl/tx_timeout_timer.sv
// Start-timeout counter: cleared on launch, counts while enabled, flags TIMEOUT_CYCLES-1.
module tx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [7:0] TERM = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  // Saturates at the terminal value so a stray enable can never wrap it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TERM)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = (r_count == TERM);

endmodule

// File: rtl/tx_packet_scheduler.sv
// Sequences one USB TX transaction at a time and serialises buffer flushes against it.
module tx_packet_scheduler
  import usb_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_PACKET     = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_tx_start,
  input  logic [1:0] i_tx_cmd,
  input  logic       i_clear_req,
  input  logic [6:0] i_buffer_occupancy,
  input  logic       i_tx_transfer_active,
  input  logic       i_tx_error,
  output logic [1:0] o_tx_packet,
  output logic       o_tx_packet_valid,
  output logic       o_clear,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_start_dropped,
  output logic [7:0] o_pkt_count
);

  sched_state_t r_state;
  tx_packet_t   r_cmd;
  err_code_t    r_err_code;
  logic         r_flush_pend;
  logic [7:0]   r_pkt_count;

  logic w_terminal;
  logic w_unlaunchable;
  logic w_flush_now;

  tx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_clear   (r_state == S_LAUNCH),
    .i_enable  (r_state == S_WAIT_START),
    .o_terminal(w_terminal)
  );

  // Oversize payloads are rejected the same way as an empty buffer.
  assign w_unlaunchable = (i_buffer_occupancy == 7'd0) ||
                          (i_buffer_occupancy > 7'(MAX_PACKET));
  assign w_flush_now    = r_flush_pend || i_clear_req;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= PKT_ACK;
      r_err_code   <= ERR_OK;
      r_flush_pend <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      if (i_clear_req && (r_state != S_IDLE)) begin
        r_flush_pend <= 1'b1;
      end else if (r_state == S_FLUSH) begin
        r_flush_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_flush_now) begin
            r_state <= S_FLUSH;
          end else if (i_tx_start) begin
            r_cmd   <= tx_packet_t'(i_tx_cmd);
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if ((r_cmd == PKT_DATA) && w_unlaunchable) begin
            r_err_code <= ERR_EMPTY;
            r_state    <= S_ERR;
          end else begin
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT_START;
        S_WAIT_START: begin
          if (i_tx_transfer_active) begin
            r_state <= S_ACTIVE;
          end else if (w_terminal) begin
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_ERR;
          end
        end
        S_ACTIVE: begin
          if (i_tx_error) begin
            r_err_code <= ERR_TXERR;
            r_state    <= S_ERR;
          end else if (!i_tx_transfer_active) begin
            r_err_code  <= ERR_OK;
            r_pkt_count <= r_pkt_count + 8'd1;
            r_state     <= S_DONE;
          end
        end
        S_FLUSH, S_DONE, S_ERR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy            = (r_state != S_IDLE);
  assign o_tx_packet_valid = (r_state == S_LAUNCH);
  assign o_tx_packet       = o_tx_packet_valid ? r_cmd : 2'd0;
  assign o_clear           = (r_state == S_FLUSH);
  assign o_done            = (r_state == S_DONE);
  assign o_err             = (r_state == S_ERR);
  assign o_err_code        = r_err_code;
  assign o_pkt_count       = r_pkt_count;

  // A start in IDLE that loses to a flush is dropped just like one arriving while busy.
  assign o_start_dropped   = i_tx_start && (o_busy || w_flush_now);

endmodule
